// File: rtl/link_pkg.sv
// link_pkg: lane levels, serializer state encoding and frame sizing shared by link transmitters/receivers.
package link_pkg;

    localparam logic LANE_IDLE  = 1'b0;
    localparam logic LANE_START = 1'b1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_GAP} state_t;

    function automatic int nbits(input int length, input int lines);
        return (length + lines - 1) / lines;
    endfunction

endpackage

// File: rtl/lane_serializer.sv
// lane_serializer: sends LENGTH-bit words over LINES lanes as START, data, optional parity and gap cycles,
// with a one-word holding buffer so the next frame can follow without idle time.
module lane_serializer
    import link_pkg::*;
#(
    parameter int LENGTH  = 128,
    parameter int LINES   = 3,
    parameter int PARITY  = 1,
    parameter int MIN_GAP = 1,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid,
    output logic              ready,
    input  logic [LENGTH-1:0] data_in,
    output logic [LINES-1:0]  d,
    output logic              busy,
    output logic [CNT_W-1:0]  frame_count
);

    localparam int NBITS = nbits(LENGTH, LINES);
    localparam int PW    = LINES * NBITS;
    localparam int BW    = $clog2(NBITS + 1);
    localparam int GW    = MIN_GAP > 0 ? $clog2(MIN_GAP + 1) : 1;
    localparam int GL    = MIN_GAP > 0 ? MIN_GAP - 1 : 0;

    state_t            state, state_nx;
    logic              hold_full, hold_full_nx;
    logic [LENGTH-1:0] hold;
    logic [PW-1:0]     sh;
    logic [LINES-1:0]  par, d_nx;
    logic [BW-1:0]     bit_cnt;
    logic [GW-1:0]     gap_cnt;
    logic              accept, take, last_bit, last_gap, body_end, frame_done;

    assign accept       = valid && ready;
    assign last_bit     = bit_cnt == BW'(NBITS - 1);
    assign last_gap     = gap_cnt == GW'(GL);
    assign busy         = state != S_IDLE;
    assign hold_full_nx = accept || (hold_full && !take);

    // A frame ends on its last gap cycle, or on its last parity/data cycle when there is no gap.
    always_comb begin
        body_end   = (state == S_DATA && last_bit && PARITY == 0) || state == S_PARITY;
        frame_done = (body_end && MIN_GAP == 0) || (state == S_GAP && last_gap);
        take       = hold_full && (state == S_IDLE || frame_done);
        d_nx       = state == S_START  ? {LINES{LANE_START}} :
                     state == S_DATA   ? sh[PW-1 -: LINES] :
                     state == S_PARITY ? par : {LINES{LANE_IDLE}};
        state_nx   = state;
        if (state == S_START) state_nx = S_DATA;
        if (state == S_DATA && last_bit) state_nx = PARITY != 0 ? S_PARITY : S_GAP;
        if (body_end) state_nx = MIN_GAP > 0 ? S_GAP : S_IDLE;
        if (frame_done) state_nx = S_IDLE;
        if (take) state_nx = S_START;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_full   <= 1'b0;
            ready       <= 1'b0;
            hold        <= '0;
            sh          <= '0;
            par         <= '0;
            d           <= '0;
            bit_cnt     <= '0;
            gap_cnt     <= '0;
            frame_count <= '0;
        end else begin
            hold_full <= hold_full_nx;
            ready     <= !hold_full_nx;
            d         <= d_nx;
            bit_cnt   <= state == S_DATA ? bit_cnt + 1'b1 : '0;
            gap_cnt   <= state == S_GAP ? gap_cnt + 1'b1 : '0;
            if (accept) hold <= data_in;
            if (take) begin
                sh  <= PW'(hold);
                par <= '0;
            end else if (state == S_DATA) begin
                sh  <= sh << LINES;
                par <= par ^ sh[PW-1 -: LINES];
            end
            if (frame_done) frame_count <= frame_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_lane_serializer.sv
// tb_lane_serializer: three serializer configurations checked cycle by cycle against a frame-schedule model.
module tb_lane_serializer;

    localparam int NI = 3;
    localparam int N  = 4096;
    localparam int LEN [NI] = '{32, 128, 20};
    localparam int LNS [NI] = '{1, 3, 3};
    localparam int PAR [NI] = '{1, 1, 0};
    localparam int GAP [NI] = '{1, 0, 3};
    localparam int CW  [NI] = '{2, 16, 16};

    logic clk = 1'b0, rst_n;
    logic [NI-1:0] valid, rdy, bsy;
    logic [127:0] din [NI];
    logic [0:0] d0;
    logic [2:0] d1, d2;
    logic [1:0] fc0;
    logic [15:0] fc1, fc2;

    bit [2:0] exp_d [NI][N];
    bit rdy_low [NI][N];
    bit exp_busy [NI][N];
    bit fc_inc [NI][N];
    int next_free [NI];
    int acc_cnt [NI];
    int fc_exp [NI];
    int fc_prev [NI];
    int cyc = 0, checks = 0, errors = 0, watch = 0;
    int ev_cyc [$];
    int ev_val [$];

    always #5 clk = ~clk;

    lane_serializer #(.LENGTH(32), .LINES(1), .PARITY(1), .MIN_GAP(1), .CNT_W(2)) u0 (
        .clk(clk), .rst_n(rst_n), .valid(valid[0]), .ready(rdy[0]), .data_in(din[0][31:0]),
        .d(d0), .busy(bsy[0]), .frame_count(fc0));
    lane_serializer #(.LENGTH(128), .LINES(3), .PARITY(1), .MIN_GAP(0), .CNT_W(16)) u1 (
        .clk(clk), .rst_n(rst_n), .valid(valid[1]), .ready(rdy[1]), .data_in(din[1]),
        .d(d1), .busy(bsy[1]), .frame_count(fc1));
    lane_serializer #(.LENGTH(20), .LINES(3), .PARITY(0), .MIN_GAP(3), .CNT_W(16)) u2 (
        .clk(clk), .rst_n(rst_n), .valid(valid[2]), .ready(rdy[2]), .data_in(din[2][19:0]),
        .d(d2), .busy(bsy[2]), .frame_count(fc2));

    task automatic check(input string tag, input logic [131:0] got, input logic [131:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] dv(input int i);
        return i == 0 ? {2'b0, d0} : i == 1 ? d1 : d2;
    endfunction

    function automatic int fcv(input int i);
        return i == 0 ? int'(fc0) : i == 1 ? int'(fc1) : int'(fc2);
    endfunction

    // A word accepted at edge t starts at t+2 or right after the previous frame, whichever is later.
    task automatic schedule(input int i, input int t, input logic [127:0] w);
        int nb, s, c;
        logic [131:0] p;
        bit [2:0] v, pr;
        nb = (LEN[i] + LNS[i] - 1) / LNS[i];
        p  = 132'(w) & ((132'(1) << LEN[i]) - 1);
        s  = t + 2 > next_free[i] ? t + 2 : next_free[i];
        exp_d[i][s] = 3'((1 << LNS[i]) - 1);
        pr = 0;
        for (int k = 0; k < nb; k++) begin
            v = 0;
            for (int j = 0; j < LNS[i]; j++) v[j] = p[(nb - 1 - k) * LNS[i] + j];
            exp_d[i][s + 1 + k] = v;
            pr ^= v;
        end
        c = s + 1 + nb;
        if (PAR[i] != 0) begin
            exp_d[i][c] = pr;
            c++;
        end
        c += GAP[i];
        fc_inc[i][c - 1] = 1;
        for (int u = t; u <= s - 2; u++) rdy_low[i][u] = 1;
        for (int u = s - 1; u < c - 1; u++) exp_busy[i][u] = 1;
        next_free[i] = c;
        acc_cnt[i]++;
    endtask

    task automatic clear_model(input int from);
        for (int i = 0; i < NI; i++) begin
            for (int u = from; u < N; u++) begin
                exp_d[i][u] = 0;
                rdy_low[i][u] = 0;
                exp_busy[i][u] = 0;
                fc_inc[i][u] = 0;
            end
            next_free[i] = 0;
            fc_exp[i] = 0;
        end
    endtask

    always @(posedge clk) begin
        if (rst_n)
            for (int i = 0; i < NI; i++)
                if (valid[i] && !rdy_low[i][cyc]) schedule(i, cyc + 1, din[i]);
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) begin
                check($sformatf("rst_d%0d@%0d", i, cyc), 132'(dv(i)), 0);
                check($sformatf("rst_ready%0d@%0d", i, cyc), 132'(rdy[i]), 0);
                check($sformatf("rst_busy%0d@%0d", i, cyc), 132'(bsy[i]), 0);
                check($sformatf("rst_fc%0d@%0d", i, cyc), 132'(fcv(i)), 0);
            end else begin
                if (fc_inc[i][cyc]) fc_exp[i] = (fc_exp[i] + 1) % (1 << CW[i]);
                check($sformatf("d%0d@%0d", i, cyc), 132'(dv(i)), 132'(exp_d[i][cyc]));
                check($sformatf("ready%0d@%0d", i, cyc), 132'(rdy[i]), 132'(!rdy_low[i][cyc]));
                check($sformatf("busy%0d@%0d", i, cyc), 132'(bsy[i]), 132'(exp_busy[i][cyc]));
                check($sformatf("fc%0d@%0d", i, cyc), 132'(fcv(i)), 132'(fc_exp[i]));
                if (i == watch && fcv(i) != fc_prev[i]) begin
                    ev_cyc.push_back(cyc);
                    ev_val.push_back(fcv(i));
                end
            end
            fc_prev[i] = fcv(i);
        end
    end

    task automatic release_rst();
        #2;
        for (int i = 0; i < NI; i++) rdy_low[i][cyc] = 1;
        rst_n = 1'b1;
    endtask

    task automatic send(input int i, input logic [127:0] w);
        int n0, k;
        n0 = acc_cnt[i];
        valid[i] = 1'b1;
        din[i] = w;
        for (k = 0; k < 200 && acc_cnt[i] == n0; k++) @(negedge clk);
        valid[i] = 1'b0;
        if (k >= 200) check("send_timeout", 0, 1);
    endtask

    task automatic wait_idle(input int i);
        int k;
        for (k = 0; k < 400 && cyc <= next_free[i]; k++) @(negedge clk);
        if (k >= 400) check("idle_timeout", 0, 1);
        @(negedge clk);
    endtask

    initial begin
        logic [34:0] got;
        logic [2:0] cap [47];
        int fc_pre, n0, k;
        rst_n = 1'b0;
        valid = '0;
        for (int i = 0; i < NI; i++) din[i] = '0;
        clear_model(0);
        repeat (3) @(negedge clk);
        release_rst();
        @(negedge clk);
        check("ready_after_reset", 132'(rdy), 132'(3'b111));

        // single 32-bit frame on one lane with parity and one gap cycle
        send(0, 128'hF0130000);
        fc_pre = 0;
        got = '0;
        for (int j = 1; j <= 36; j++) begin
            @(negedge clk);
            if (j >= 2) got[36 - j] = d0;
            if (j == 35) fc_pre = fcv(0);
        end
        check("t1_stream", 132'(got), 132'({1'b1, 32'hF0130000, 1'b1, 1'b0}));
        check("t1_fc_before_last", 132'(fc_pre), 0);
        check("t1_fc_after", 132'(fcv(0)), 1);

        // 128-bit word over three lanes: padding lane bits come first
        wait_idle(1);
        send(1, 128'h1);
        for (int j = 1; j <= 46; j++) begin
            @(negedge clk);
            cap[j] = d1;
        end
        check("t2_start", 132'(cap[2]), 132'(3'b111));
        check("t2_first_data", 132'(cap[3]), 0);
        check("t2_last_data", 132'(cap[45]), 132'(3'b001));
        check("t2_parity", 132'(cap[46]), 132'(3'b001));

        // back-to-back frames with valid held high
        wait_idle(1);
        watch = 1;
        ev_cyc.delete();
        ev_val.delete();
        n0 = acc_cnt[1];
        valid[1] = 1'b1;
        din[1] = {$urandom, $urandom, $urandom, $urandom};
        for (k = 0; k < 300 && acc_cnt[1] - n0 < 3; k++) begin
            @(negedge clk);
            din[1] = {$urandom, $urandom, $urandom, $urandom};
        end
        valid[1] = 1'b0;
        if (k >= 300) check("t3_accept_timeout", 0, 1);
        repeat (150) @(negedge clk);
        check("t3_frames", 132'(ev_cyc.size()), 3);
        if (ev_cyc.size() == 3) begin
            check("t3_period_a", 132'(ev_cyc[1] - ev_cyc[0]), 45);
            check("t3_period_b", 132'(ev_cyc[2] - ev_cyc[1]), 45);
            check("t3_count", 132'(ev_val[2]), 4);
        end

        // asynchronous reset during data cycle 10
        wait_idle(1);
        send(1, {128{1'b1}});
        repeat (12) @(negedge clk);
        @(posedge clk);
        #1;
        check("t4_pre_d", 132'(d1), 132'(3'b111));
        check("t4_pre_fc", 132'(fc1), 4);
        #1;
        rst_n = 1'b0;
        clear_model(cyc);
        #1;
        check("t4_async_d", 132'(d1), 0);
        check("t4_async_ready", 132'(rdy[1]), 0);
        check("t4_async_busy", 132'(bsy[1]), 0);
        check("t4_async_fc", 132'(fc1), 0);
        repeat (2) @(negedge clk);
        release_rst();
        @(negedge clk);
        check("t4_ready_back", 132'(rdy[1]), 1);
        send(1, {$urandom, $urandom, $urandom, $urandom});
        repeat (2) @(negedge clk);
        check("t4_clean_start", 132'(d1), 132'(3'b111));

        // two-bit frame counter wraps
        wait_idle(0);
        watch = 0;
        ev_cyc.delete();
        ev_val.delete();
        for (int j = 0; j < 5; j++) send(0, {96'b0, $urandom});
        repeat (250) @(negedge clk);
        check("t5_events", 132'(ev_val.size()), 5);
        if (ev_val.size() == 5)
            for (int j = 0; j < 5; j++) check($sformatf("t5_count%0d", j), 132'(ev_val[j]), 132'((j + 1) % 4));

        // no parity, three gap cycles ahead of a queued frame
        wait_idle(2);
        watch = 2;
        ev_cyc.delete();
        ev_val.delete();
        send(2, {108'b0, 20'($urandom)});
        send(2, {108'b0, 20'($urandom)});
        repeat (60) @(negedge clk);
        check("t6_events", 132'(ev_cyc.size()), 2);
        if (ev_cyc.size() == 2) check("t6_period", 132'(ev_cyc[1] - ev_cyc[0]), 11);

        // random traffic on all three configurations
        while (cyc < 3400) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                valid[i] = $urandom_range(0, 2) != 0;
                din[i] = {$urandom, $urandom, $urandom, $urandom};
            end
        end
        valid = '0;
        repeat (300) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
